// File: rtl/node_event_scheduler.sv
// Turns parsed node lines (one source beat, then edge beats up to edge_last) into
// one-cycle mapper strobes. Optional counters: define NODE_EVENT_SCHED_STATS_EN.
module node_event_scheduler #(
  parameter int NODE_STR_WIDTH = 15,
  parameter int DONE_GUARD     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_valid,
  output logic                      src_ready,
  input  logic [NODE_STR_WIDTH-1:0] src_str,
  input  logic                      edge_valid,
  output logic                      edge_ready,
  input  logic [NODE_STR_WIDTH-1:0] edge_str,
  input  logic                      edge_last,
  input  logic                      input_done,
  output logic                      src_node_str_valid,
  output logic [NODE_STR_WIDTH-1:0] src_node_str,
  output logic                      edge_str_valid,
  output logic [NODE_STR_WIDTH-1:0] dst_node_str,
  output logic                      decoding_done_str,
  output logic                      busy
`ifdef NODE_EVENT_SCHED_STATS_EN
  ,
  output logic [15:0]               src_cnt,
  output logic [15:0]               edge_cnt,
  output logic [15:0]               stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SRC, EDGE, GUARD, DONE} state_t;

  localparam logic [2:0] GUARD_LAST = 3'(DONE_GUARD - 1);

  state_t     state_reg, state_next;
  logic [2:0] guard_cnt_reg;
  logic       src_accept;
  logic       edge_accept;
  logic       guard_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      guard_cnt_reg      <= '0;
      src_node_str_valid <= 1'b0;
      src_node_str       <= '0;
      edge_str_valid     <= 1'b0;
      dst_node_str       <= '0;
      decoding_done_str  <= 1'b0;
    end else begin
      state_reg          <= state_next;
      src_node_str_valid <= src_accept;
      edge_str_valid     <= edge_accept;
      decoding_done_str  <= guard_expire;
      if (src_accept)
        src_node_str <= src_str;
      if (edge_accept)
        dst_node_str <= edge_str;
      // Counter only runs while waiting out the guard interval.
      if (state_reg == GUARD)
        guard_cnt_reg <= guard_cnt_reg + 3'd1;
      else
        guard_cnt_reg <= '0;
    end
  end

  // Readies come from state alone so no valid-to-ready combinational path exists.
  always_comb begin
    state_next   = state_reg;
    src_ready    = 1'b0;
    edge_ready   = 1'b0;
    busy         = 1'b0;
    src_accept   = 1'b0;
    edge_accept  = 1'b0;
    guard_expire = 1'b0;
    case (state_reg)
      IDLE: state_next = SRC;
      SRC: begin
        src_ready = 1'b1;
        busy      = 1'b1;
        if (src_valid) begin
          src_accept = 1'b1;
          state_next = EDGE;
        end else if (input_done) begin
          state_next = GUARD;
        end
      end
      EDGE: begin
        edge_ready = 1'b1;
        busy       = 1'b1;
        if (edge_valid) begin
          edge_accept = 1'b1;
          if (edge_last)
            state_next = SRC;
        end
      end
      GUARD: begin
        busy = 1'b1;
        if (guard_cnt_reg == GUARD_LAST) begin
          guard_expire = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

`ifdef NODE_EVENT_SCHED_STATS_EN
  logic stall;
  assign stall = (src_valid && !src_ready) || (edge_valid && !edge_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_cnt   <= '0;
      edge_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (src_node_str_valid && (src_cnt != 16'hFFFF))
        src_cnt <= src_cnt + 16'd1;
      if (edge_str_valid && (edge_cnt != 16'hFFFF))
        edge_cnt <= edge_cnt + 16'd1;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_node_event_scheduler.sv
// Bench for node_event_scheduler: directed vector table for the corner cases,
// then random lines checked against a queue scoreboard of expected strobes.
`timescale 1ns/1ps
module tb_node_event_scheduler;
  localparam int W  = 15;
  localparam int DG = 2;
  localparam int NL = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         src_valid;
  logic         src_ready;
  logic [W-1:0] src_str;
  logic         edge_valid;
  logic         edge_ready;
  logic [W-1:0] edge_str;
  logic         edge_last;
  logic         input_done;
  logic         src_node_str_valid;
  logic [W-1:0] src_node_str;
  logic         edge_str_valid;
  logic [W-1:0] dst_node_str;
  logic         decoding_done_str;
  logic         busy;
`ifdef NODE_EVENT_SCHED_STATS_EN
  logic [15:0]  src_cnt;
  logic [15:0]  edge_cnt;
  logic [15:0]  stall_cnt;
`endif

  node_event_scheduler #(.NODE_STR_WIDTH(W), .DONE_GUARD(DG)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_str(src_str),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_str(edge_str),
    .edge_last(edge_last), .input_done(input_done),
    .src_node_str_valid(src_node_str_valid), .src_node_str(src_node_str),
    .edge_str_valid(edge_str_valid), .dst_node_str(dst_node_str),
    .decoding_done_str(decoding_done_str), .busy(busy)
`ifdef NODE_EVENT_SCHED_STATS_EN
    , .src_cnt(src_cnt), .edge_cnt(edge_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Three lowercase letters packed 5 bits each, first letter in the top field.
  function automatic logic [W-1:0] s3(input string s);
    logic [W-1:0] r;
    byte c;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      c = s[i];
      r = {r[W-6:0], c[4:0]};
    end
    return r;
  endfunction

  typedef struct {
    logic         chk;
    logic         rst, sv;
    logic [W-1:0] ss;
    logic         ev;
    logic [W-1:0] es;
    logic         el, idn;
    logic         x_sr, x_er, x_sv;
    logic [W-1:0] x_ss;
    logic         x_ev;
    logic [W-1:0] x_ds;
    logic         x_done, x_busy;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic c, r, sv_i, input logic [W-1:0] ss_i,
                              input logic ev_i, input logic [W-1:0] es_i, input logic el_i, id_i,
                              input logic xsr, xer, xsv, input logic [W-1:0] xss,
                              input logic xev, input logic [W-1:0] xds, input logic xd, xb);
    vec_t v;
    v.chk = c; v.rst = r; v.sv = sv_i; v.ss = ss_i; v.ev = ev_i; v.es = es_i;
    v.el = el_i; v.idn = id_i; v.x_sr = xsr; v.x_er = xer; v.x_sv = xsv; v.x_ss = xss;
    v.x_ev = xev; v.x_ds = xds; v.x_done = xd; v.x_busy = xb;
    vecs.push_back(v);
  endfunction

  typedef struct {
    bit           is_edge;
    logic [W-1:0] s;
    bit           last;
    bit           hold;
  } item_t;
  item_t items[$];

  initial begin
    logic [W-1:0] z, you, aaa, out, zzz, abc, def, ghi, xyz, bcd;
    item_t        it, pend;
    bit           pend_v, hold, fin, offer, exp_sr, exp_er, acc;
    int           ne, cyc, done_start, src_m, edge_m, stall_m;

    rst = 1'b1; src_valid = 1'b0; src_str = '0; edge_valid = 1'b0; edge_str = '0;
    edge_last = 1'b0; input_done = 1'b0;
    z = '0;
    you = s3("you"); aaa = s3("aaa"); out = s3("out"); zzz = s3("zzz");
    abc = s3("abc"); def = s3("def"); ghi = s3("ghi"); xyz = s3("xyz"); bcd = s3("bcd");

    //   chk rst sv ss   ev es   el id | sr er sv ss   ev ds   dn by
    add(0, 1, 0, z,   0, z,   0, 0,   0, 0, 0, z,   0, z,   0, 0);
    add(1, 0, 0, z,   1, zzz, 0, 0,   0, 0, 0, z,   0, z,   0, 0);
    add(1, 0, 0, z,   1, zzz, 0, 0,   1, 0, 0, z,   0, z,   0, 1);
    add(1, 0, 1, you, 1, zzz, 0, 0,   1, 0, 0, z,   0, z,   0, 1);
    add(1, 0, 0, z,   1, aaa, 0, 0,   0, 1, 1, you, 0, z,   0, 1);
    add(1, 0, 0, z,   1, out, 1, 1,   0, 1, 0, you, 1, aaa, 0, 1);
    add(1, 0, 0, z,   0, z,   0, 1,   1, 0, 0, you, 1, out, 0, 1);
    add(1, 0, 0, z,   0, z,   0, 1,   0, 0, 0, you, 0, out, 0, 1);
    add(1, 0, 0, z,   0, z,   0, 1,   0, 0, 0, you, 0, out, 0, 1);
    add(1, 0, 0, z,   0, z,   0, 1,   0, 0, 0, you, 0, out, 1, 0);
    add(1, 0, 1, abc, 1, def, 0, 1,   0, 0, 0, you, 0, out, 0, 0);
    add(1, 1, 0, z,   0, z,   0, 0,   0, 0, 0, you, 0, out, 0, 0);
    add(1, 0, 0, z,   0, z,   0, 0,   0, 0, 0, z,   0, z,   0, 0);
    add(1, 0, 1, abc, 0, z,   0, 0,   1, 0, 0, z,   0, z,   0, 1);
    add(1, 0, 0, z,   1, def, 0, 0,   0, 1, 1, abc, 0, z,   0, 1);
    add(1, 1, 0, z,   1, ghi, 0, 0,   0, 1, 0, abc, 1, def, 0, 1);
    add(1, 0, 0, z,   0, z,   0, 0,   0, 0, 0, z,   0, z,   0, 0);
    add(1, 0, 1, xyz, 0, z,   0, 0,   1, 0, 0, z,   0, z,   0, 1);
    add(1, 0, 0, z,   1, bcd, 1, 0,   0, 1, 1, xyz, 0, z,   0, 1);
    add(1, 0, 0, z,   0, z,   0, 0,   1, 0, 0, xyz, 1, bcd, 0, 1);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; src_valid = vecs[i].sv; src_str = vecs[i].ss;
      edge_valid = vecs[i].ev; edge_str = vecs[i].es; edge_last = vecs[i].el;
      input_done = vecs[i].idn;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d.src_ready", i), src_ready, vecs[i].x_sr);
        check($sformatf("v%0d.edge_ready", i), edge_ready, vecs[i].x_er);
        check($sformatf("v%0d.src_strobe", i), src_node_str_valid, vecs[i].x_sv);
        check($sformatf("v%0d.src_node_str", i), src_node_str, vecs[i].x_ss);
        check($sformatf("v%0d.edge_strobe", i), edge_str_valid, vecs[i].x_ev);
        check($sformatf("v%0d.dst_node_str", i), dst_node_str, vecs[i].x_ds);
        check($sformatf("v%0d.done", i), decoding_done_str, vecs[i].x_done);
        check($sformatf("v%0d.busy", i), busy, vecs[i].x_busy);
      end
      $display("vec %0d: rst=%0b sv=%0b ev=%0b el=%0b done_in=%0b -> sr=%0b er=%0b s_stb=%0b e_stb=%0b done=%0b",
               i, rst, src_valid, edge_valid, edge_last, input_done,
               src_ready, edge_ready, src_node_str_valid, edge_str_valid, decoding_done_str);
      @(posedge clk); #1;
    end

    // Random lines; the first three carry two edges each with valids held high.
    for (int l = 0; l < NL; l++) begin
      hold = (l < 3);
      ne = hold ? 2 : int'($urandom_range(1, 4));
      it.is_edge = 1'b0; it.s = W'($urandom); it.last = 1'b0; it.hold = hold;
      items.push_back(it);
      $display("line %0d: src=%h edges=%0d hold=%0b", l, it.s, ne, hold);
      for (int e = 0; e < ne; e++) begin
        it.is_edge = 1'b1; it.s = W'($urandom); it.last = (e == ne - 1);
        items.push_back(it);
      end
    end

    rst = 1'b1; src_valid = 1'b0; edge_valid = 1'b0; input_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pend_v = 1'b0; fin = 1'b0; cyc = 0; done_start = -1;
    src_m = 0; edge_m = 0; stall_m = 0;
    while (!fin) begin
      check("rnd.src_strobe", src_node_str_valid, pend_v && !pend.is_edge);
      check("rnd.edge_strobe", edge_str_valid, pend_v && pend.is_edge);
      if (pend_v && !pend.is_edge) check("rnd.src_node_str", src_node_str, pend.s);
      if (pend_v && pend.is_edge) check("rnd.dst_node_str", dst_node_str, pend.s);
      if (pend_v && !pend.is_edge) src_m++;
      if (pend_v && pend.is_edge) edge_m++;

      if (items.size() == 0 && done_start < 0) done_start = cyc;
      exp_sr = (cyc > 0) && ((items.size() > 0) ? !items[0].is_edge : (cyc == done_start));
      exp_er = (cyc > 0) && (items.size() > 0) && items[0].is_edge;
      check("rnd.src_ready", src_ready, exp_sr);
      check("rnd.edge_ready", edge_ready, exp_er);
      check("rnd.done", decoding_done_str, (done_start >= 0) && (cyc == done_start + DG + 1));
      check("rnd.busy", busy, (cyc > 0) && !((done_start >= 0) && (cyc >= done_start + DG + 1)));

      src_valid = 1'b0; edge_valid = 1'b0; input_done = 1'b0;
      if (items.size() > 0) begin
        offer = items[0].hold ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (!items[0].is_edge) begin
          src_valid = offer; src_str = items[0].s;
          if (!items[0].hold && $urandom_range(0, 3) == 0) begin
            edge_valid = 1'b1; edge_str = W'($urandom); edge_last = 1'($urandom);
          end
        end else begin
          edge_valid = offer; edge_str = items[0].s; edge_last = items[0].last;
          if (!items[0].hold && $urandom_range(0, 3) == 0) begin
            src_valid = 1'b1; src_str = W'($urandom);
          end
        end
      end else begin
        input_done = 1'b1;
      end
      if ((src_valid && !exp_sr) || (edge_valid && !exp_er)) stall_m++;

      pend_v = 1'b0;
      if (items.size() > 0) begin
        acc = items[0].is_edge ? (edge_valid && edge_ready) : (src_valid && src_ready);
        if (acc) begin
          pend = items.pop_front();
          pend_v = 1'b1;
        end
      end

      if (done_start >= 0 && cyc == done_start + DG + 3) fin = 1'b1;
      if (cyc == 4000) begin
        check("rnd.timeout", 32'd1, 32'd0);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end

`ifdef NODE_EVENT_SCHED_STATS_EN
    check("stats.src_cnt", src_cnt, src_m);
    check("stats.edge_cnt", edge_cnt, edge_m);
    check("stats.stall_cnt", stall_cnt, stall_m);
`endif
    $display("random: src strobes=%0d edge strobes=%0d stall cycles=%0d", src_m, edge_m, stall_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
